// File: rtl/parking_ctrl_param.sv
// parking_ctrl_param
//   Two-class (university / free) parking occupancy controller. Free capacity
//   follows the wall-clock hour: BASE_FREE up to and including RAMP_START, then
//   grows by RAMP_STEP per hour until it reaches MAX_FREE. University capacity
//   is whatever remains of TOTAL_CAP. Every output is registered.
//
//   Optional feature macro: PARKING_STATS_EN
//     When defined, adds per-class 16-bit saturating reject counters and the
//     peak combined occupancy seen since reset.
//
// Ports
//   clk                 rising-edge system clock
//   reset               synchronous, active-low reset
//   car_entered         entry request this cycle
//   is_uni_car_entered  entry class (1 = university, 0 = free)
//   car_exited          exit event this cycle
//   is_uni_car_exited   exit class (1 = university, 0 = free)
//   hour                wall-clock hour, 0..23 legal
//   uni_parked_car      university occupancy
//   parked_car          free occupancy
//   uni_vacated_space   university spaces remaining (saturating at 0)
//   vacated_space       free spaces remaining (saturating at 0)
//   uni_is_vacated_space / is_vacated_space   space-remaining flags
//   entry_accept        pulse: previous-cycle entry counted
//   entry_reject        pulse: previous-cycle entry refused (class full)
//   exit_error          pulse: exit requested while class count was 0
//   hour_err            registered: hour input was > 23
//   uni_reject_cnt, free_reject_cnt, peak_occupancy   (PARKING_STATS_EN only)

module parking_ctrl_param #(
    parameter int unsigned CW         = 10,
    parameter int unsigned TOTAL_CAP  = 700,
    parameter int unsigned BASE_FREE  = 200,
    parameter int unsigned MAX_FREE   = 500,
    parameter int unsigned RAMP_START = 13,
    parameter int unsigned RAMP_STEP  = 100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          car_entered,
    input  logic          is_uni_car_entered,
    input  logic          car_exited,
    input  logic          is_uni_car_exited,
    input  logic [4:0]    hour,
    output logic [CW-1:0] uni_parked_car,
    output logic [CW-1:0] parked_car,
    output logic [CW-1:0] uni_vacated_space,
    output logic [CW-1:0] vacated_space,
    output logic          uni_is_vacated_space,
    output logic          is_vacated_space,
    output logic          entry_accept,
    output logic          entry_reject,
    output logic          exit_error,
    output logic          hour_err
`ifdef PARKING_STATS_EN
    ,
    output logic [15:0]   uni_reject_cnt,
    output logic [15:0]   free_reject_cnt,
    output logic [CW-1:0] peak_occupancy
`endif
);

    logic [CW-1:0] uni_cnt_q, uni_cnt_d, free_cnt_q, free_cnt_d;
    logic [CW-1:0] uni_cap_q, uni_cap_d, free_cap_q, free_cap_d;
    logic [CW-1:0] uni_vac_q, uni_vac_d, free_vac_q, free_vac_d;
    logic          acc_q, acc_d, rej_q, rej_d, xerr_q, xerr_d;
    logic          herr_q, herr_d;

    logic          u_entry, f_entry, u_exit, f_exit;
    logic          u_exit_ok, f_exit_ok, u_acc, f_acc;
    logic [CW-1:0] u_base, f_base;
    int unsigned   hr, fc;

    // Capacity for the next cycle; an illegal hour keeps the previous capacities.
    always_comb begin
        hr         = 32'(hour);
        fc         = BASE_FREE;
        free_cap_d = free_cap_q;
        uni_cap_d  = uni_cap_q;
        herr_d     = 1'b0;
        if (hr > 23) begin
            herr_d = 1'b1;
        end else begin
            if (hr > RAMP_START) begin
                fc = BASE_FREE + RAMP_STEP * (hr - RAMP_START);
                if (fc > MAX_FREE) fc = MAX_FREE;
            end
            free_cap_d = CW'(fc);
            uni_cap_d  = CW'(TOTAL_CAP - fc);
        end
    end

    // Per-class occupancy. The exit is applied first so that a simultaneous
    // exit can free the slot an entry of the same class needs. Requests are
    // judged against the currently registered capacity.
    always_comb begin
        u_entry   = car_entered && is_uni_car_entered;
        f_entry   = car_entered && !is_uni_car_entered;
        u_exit    = car_exited && is_uni_car_exited;
        f_exit    = car_exited && !is_uni_car_exited;

        u_exit_ok = u_exit && (uni_cnt_q != '0);
        f_exit_ok = f_exit && (free_cnt_q != '0);
        u_base    = uni_cnt_q - CW'(u_exit_ok);
        f_base    = free_cnt_q - CW'(f_exit_ok);
        u_acc     = u_entry && (u_base < uni_cap_q);
        f_acc     = f_entry && (f_base < free_cap_q);

        uni_cnt_d  = u_acc ? u_base + CW'(1) : u_base;
        free_cnt_d = f_acc ? f_base + CW'(1) : f_base;

        acc_d  = u_acc || f_acc;
        rej_d  = (u_entry && !u_acc) || (f_entry && !f_acc);
        xerr_d = (u_exit && !u_exit_ok) || (f_exit && !f_exit_ok);

        // Capacity may drop below occupancy after an hour change: clamp to 0.
        uni_vac_d  = (uni_cap_d > uni_cnt_d) ? uni_cap_d - uni_cnt_d : '0;
        free_vac_d = (free_cap_d > free_cnt_d) ? free_cap_d - free_cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            uni_cnt_q  <= '0;
            free_cnt_q <= '0;
            free_cap_q <= CW'(BASE_FREE);
            uni_cap_q  <= CW'(TOTAL_CAP - BASE_FREE);
            free_vac_q <= CW'(BASE_FREE);
            uni_vac_q  <= CW'(TOTAL_CAP - BASE_FREE);
            acc_q      <= 1'b0;
            rej_q      <= 1'b0;
            xerr_q     <= 1'b0;
            herr_q     <= 1'b0;
        end else begin
            uni_cnt_q  <= uni_cnt_d;
            free_cnt_q <= free_cnt_d;
            free_cap_q <= free_cap_d;
            uni_cap_q  <= uni_cap_d;
            free_vac_q <= free_vac_d;
            uni_vac_q  <= uni_vac_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            xerr_q     <= xerr_d;
            herr_q     <= herr_d;
        end
    end

    assign uni_parked_car       = uni_cnt_q;
    assign parked_car           = free_cnt_q;
    assign uni_vacated_space    = uni_vac_q;
    assign vacated_space        = free_vac_q;
    assign uni_is_vacated_space = (uni_vac_q != '0);
    assign is_vacated_space     = (free_vac_q != '0);
    assign entry_accept         = acc_q;
    assign entry_reject         = rej_q;
    assign exit_error           = xerr_q;
    assign hour_err             = herr_q;

`ifdef PARKING_STATS_EN
    logic [15:0]   u_rej_q, u_rej_d, f_rej_q, f_rej_d;
    logic [CW-1:0] peak_q, peak_d, occ_sum;

    always_comb begin
        u_rej_d = u_rej_q;
        f_rej_d = f_rej_q;
        if (u_entry && !u_acc && (u_rej_q != '1)) u_rej_d = u_rej_q + 16'd1;
        if (f_entry && !f_acc && (f_rej_q != '1)) f_rej_d = f_rej_q + 16'd1;
        occ_sum = uni_cnt_d + free_cnt_d;
        peak_d  = (occ_sum > peak_q) ? occ_sum : peak_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            u_rej_q <= '0;
            f_rej_q <= '0;
            peak_q  <= '0;
        end else begin
            u_rej_q <= u_rej_d;
            f_rej_q <= f_rej_d;
            peak_q  <= peak_d;
        end
    end

    assign uni_reject_cnt  = u_rej_q;
    assign free_reject_cnt = f_rej_q;
    assign peak_occupancy  = peak_q;
`endif

endmodule

// File: tb/tb_parking_ctrl_param.sv
// Scoreboard bench for parking_ctrl_param: the driver pushes the hand-derived
// expected response of each clock edge; the monitor pops and compares it on
// the following falling edge.

module tb_parking_ctrl_param;

    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          car_entered = 1'b0, is_uni_car_entered = 1'b0;
    logic          car_exited = 1'b0, is_uni_car_exited = 1'b0;
    logic [4:0]    hour = 5'd10;
    logic [CW-1:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
    logic          uni_is_vacated_space, is_vacated_space;
    logic          entry_accept, entry_reject, exit_error, hour_err;

    always #5 clk = ~clk;

    parking_ctrl_param #(
        .CW(CW), .TOTAL_CAP(700), .BASE_FREE(200), .MAX_FREE(500),
        .RAMP_START(13), .RAMP_STEP(100)
    ) dut (
        .clk(clk), .reset(reset),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .hour(hour),
        .uni_parked_car(uni_parked_car), .parked_car(parked_car),
        .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .entry_accept(entry_accept), .entry_reject(entry_reject),
        .exit_error(exit_error), .hour_err(hour_err)
    );

    // {acc, rej, xerr, herr, uflag, fflag, ucnt, fcnt, uvac, fvac}
    typedef logic [6+4*CW-1:0] resp_t;

    resp_t       exp_q[$];
    int          id_q[$];
    int          step_id = 0;
    int unsigned n_tests = 0, n_fail = 0;

    always @(negedge clk) begin
        resp_t act, e;
        int    id;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            id  = id_q.pop_front();
            act = {entry_accept, entry_reject, exit_error, hour_err,
                   uni_is_vacated_space, is_vacated_space,
                   uni_parked_car, parked_car, uni_vacated_space, vacated_space};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL step%0d: got acc/rej/xerr/herr/uf/ff=%b ucnt=%0d fcnt=%0d uvac=%0d fvac=%0d, expected %b ucnt=%0d fcnt=%0d uvac=%0d fvac=%0d",
                         id, act[4*CW+5:4*CW], act[4*CW-1:3*CW], act[3*CW-1:2*CW],
                         act[2*CW-1:CW], act[CW-1:0],
                         e[4*CW+5:4*CW], e[4*CW-1:3*CW], e[3*CW-1:2*CW],
                         e[2*CW-1:CW], e[CW-1:0]);
            end
        end
    end

    // Drive one cycle and queue the response expected right after its edge.
    task automatic cyc(input logic rn, input logic en, input logic eu,
                       input logic ex, input logic xu, input logic [4:0] hr,
                       input logic acc, input logic rej, input logic xerr,
                       input logic herr, input int unsigned uc, input int unsigned fc,
                       input int unsigned uv, input int unsigned fv);
        reset              = rn;
        car_entered        = en;
        is_uni_car_entered = eu;
        car_exited         = ex;
        is_uni_car_exited  = xu;
        hour               = hr;
        step_id++;
        exp_q.push_back({acc, rej, xerr, herr, uv != 0, fv != 0,
                         CW'(uc), CW'(fc), CW'(uv), CW'(fv)});
        id_q.push_back(step_id);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned c;

        // Reset, including a request that reset must override.
        cyc(0, 1, 1, 0, 0, 10,  0, 0, 0, 0,  0, 0, 500, 200);
        cyc(0, 0, 0, 0, 0, 10,  0, 0, 0, 0,  0, 0, 500, 200);
        cyc(1, 0, 0, 0, 0, 10,  0, 0, 0, 0,  0, 0, 500, 200);

        // One entry and one exit per class.
        cyc(1, 1, 1, 0, 0, 10,  1, 0, 0, 0,  1, 0, 499, 200);
        cyc(1, 1, 0, 0, 0, 10,  1, 0, 0, 0,  1, 1, 499, 199);
        cyc(1, 0, 0, 1, 1, 10,  0, 0, 0, 0,  0, 1, 500, 199);
        cyc(1, 0, 0, 1, 0, 10,  0, 0, 0, 0,  0, 0, 500, 200);

        // Hour-driven capacity ramp and illegal hour hold.
        cyc(1, 0, 0, 0, 0, 13,  0, 0, 0, 0,  0, 0, 500, 200);
        cyc(1, 0, 0, 0, 0, 14,  0, 0, 0, 0,  0, 0, 400, 300);
        cyc(1, 0, 0, 0, 0, 16,  0, 0, 0, 0,  0, 0, 200, 500);
        cyc(1, 0, 0, 0, 0, 25,  0, 0, 0, 1,  0, 0, 200, 500);
        cyc(1, 0, 0, 0, 0, 15,  0, 0, 0, 0,  0, 0, 300, 400);
        cyc(1, 0, 0, 0, 0, 31,  0, 0, 0, 1,  0, 0, 300, 400);
        cyc(1, 0, 0, 0, 0, 23,  0, 0, 0, 0,  0, 0, 200, 500);
        cyc(1, 0, 0, 0, 0, 10,  0, 0, 0, 0,  0, 0, 500, 200);

        // Fill free class past capacity: 200 accepts then 50 rejects.
        for (int i = 0; i < 250; i++)
            cyc(1, 1, 0, 0, 0, 10,  i < 200, i >= 200, 0, 0,
                0, (i < 200) ? i + 1 : 200, 500, (i < 200) ? 199 - i : 0);

        // Fill university class: 500 accepts then 100 rejects.
        for (int i = 0; i < 600; i++)
            cyc(1, 1, 1, 0, 0, 10,  i < 500, i >= 500, 0, 0,
                (i < 500) ? i + 1 : 500, 200, (i < 500) ? 499 - i : 0, 0);

        // Full class with simultaneous entry+exit: slot reused, count unchanged.
        cyc(1, 1, 0, 1, 0, 10,  1, 0, 0, 0,  500, 200, 0, 0);
        cyc(1, 1, 1, 1, 1, 10,  1, 0, 0, 0,  500, 200, 0, 0);

        // Hour 16 shrinks university capacity to 200 below its occupancy.
        cyc(1, 0, 0, 0, 0, 16,  0, 0, 0, 0,  500, 200, 0, 300);
        cyc(1, 1, 1, 0, 0, 16,  0, 1, 0, 0,  500, 200, 0, 300);
        for (int i = 0; i < 301; i++) begin
            c = 499 - i;
            cyc(1, 0, 0, 1, 1, 16,  0, 0, 0, 0,  c, 200, (c < 200) ? 200 - c : 0, 300);
        end
        cyc(1, 1, 1, 0, 0, 16,  1, 0, 0, 0,  200, 200, 0, 300);
        cyc(1, 1, 1, 0, 0, 16,  0, 1, 0, 0,  200, 200, 0, 300);

        // Exits on empty classes.
        cyc(0, 0, 0, 0, 0, 16,  0, 0, 0, 0,  0, 0, 500, 200);
        cyc(1, 0, 0, 1, 0, 10,  0, 0, 1, 0,  0, 0, 500, 200);
        cyc(1, 0, 0, 1, 1, 10,  0, 0, 1, 0,  0, 0, 500, 200);
        cyc(1, 1, 0, 1, 0, 10,  1, 0, 1, 0,  0, 1, 500, 199);
        cyc(1, 0, 0, 0, 0, 10,  0, 0, 0, 0,  0, 1, 500, 199);

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
